pong_sound_sequencer: RTL
=========================

# pong_sound_sequencer

- Owns the single piezo/audio pin and shares it among three game-event requesters: wall hit, paddle hit and score.
- Each event plays a fixed-pitch square-wave tone for a fixed duration, followed by a silent gap.
- Simultaneous or overlapping requests are latched and served by fixed priority.
- Sits between the game-logic FSM, which supplies single-cycle event pulses, and the board audio output. It replaces free-running per-tone dividers.

## Interface
- CLK_HZ, 100_000_000: input clock frequency.
- MS_CYCLES, CLK_HZ/1000: clock cycles per 1 ms tick.
- HALF_WALL, 50_000: half-period of the wall tone in cycles (1 kHz).
- HALF_PADDLE, 25_000: half-period of the paddle tone (2 kHz).
- HALF_SCORE, 100_000: half-period of the score tone (500 Hz).
- DUR_WALL, 30; DUR_PADDLE, 50; DUR_SCORE, 300: tone durations in ms. A value of 0 is treated as 1.
- GAP_MS, 20: silent gap after each completed tone, in ms.
- clk_100MHz  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- i_req_wall  input  1  single-cycle request pulse.
- i_req_paddle  input  1  single-cycle request pulse.
- i_req_score  input  1  single-cycle request pulse.
- o_audio  output  1  square-wave audio output.
- o_busy  output  1  high in PLAY or GAP.
- o_active_id  output  2  0 = none, 1 = wall, 2 = paddle, 3 = score.
- o_done  output  1  one-cycle pulse on natural completion of a tone.

## Operation
- **Pending latches.** Each requester has one pending bit, set on any edge where its request input is high.
  - Requests while the bit is already set merge; no counting.
  - Requests for the currently playing id set the bit again, so the tone replays after the gap.
- **Priority:** score > paddle > wall.
- **State machine:** IDLE, PLAY, GAP.
  - **IDLE:** if any pending bit is set, go to PLAY.
    - Select the highest-priority pending id and clear its bit.
    - Load the half-period counter to 0, the ms counter to 0 and the remaining-ms counter to DUR.
    - Set o_audio = 1 and o_active_id = id.
  - **PLAY:** the half counter counts 0..HALF-1. At HALF-1 it wraps to 0 and o_audio toggles.
    - The ms counter counts 0..MS_CYCLES-1 and generates a tick at the wrap.
    - Each tick decrements remaining-ms. A tick while remaining-ms = 1 ends the tone: o_audio <= 0, o_done pulses, o_active_id <= 0, go to GAP.
  - **GAP:** silent for exactly GAP_MS*MS_CYCLES cycles, then go to IDLE. Pending bits still latch during GAP.
- **Counter widths:** $clog2 of the largest parameter value plus 1. No overflow is possible within the legal parameter range.
- **Request on the same edge the bit is cleared by selection:** the bit stays set, and the tone replays.
- **Reset** (any state, mid-tone included): state = IDLE, all pending bits = 0, all counters = 0, o_audio = 0, o_busy = 0, o_active_id = 0, o_done = 0. Requests sampled during reset are ignored.

## Timing
- A request sampled at edge N sets pending at edge N.
- IDLE selects at edge N+1, so o_audio first goes high after edge N+1, i.e. 2 cycles of latency from the request edge.
- Tone length is exactly DUR*MS_CYCLES cycles. o_audio toggles every HALF cycles, starting high.
- o_done is high for the single cycle after the last PLAY edge, concurrent with the first GAP cycle.
- o_busy is a registered output: high from the PLAY entry edge through the final GAP cycle. It is low in the IDLE cycle between the gap and the next tone.

## Configuration
- **SOUND_PREEMPT_EN defined:** in PLAY, if a pending id of strictly higher priority than the active id exists, the next edge restarts PLAY with that id.
  - Its pending bit is cleared and all counters are reloaded.
  - No gap and no o_done for the aborted tone. The aborted tone is discarded, not re-queued.
- **SOUND_PREEMPT_EN undefined:** a tone always runs to completion, and higher-priority requests wait for GAP and IDLE.

## Test plan
All scenarios use MS_CYCLES=10, HALF_WALL=5, HALF_PADDLE=3, HALF_SCORE=2, DUR_WALL=2, DUR_PADDLE=3, DUR_SCORE=4, GAP_MS=1.

- **Single paddle pulse at edge 0:**
  - Required: o_audio high after edge 1 for 30 cycles, period 6, 5 rising edges; o_active_id = 2.
  - o_done pulses after edge 31; o_busy falls after edge 41.
- **i_req_wall and i_req_score on the same edge:**
  - Required: score plays first (40 cycles, period 4), then 10 gap cycles, 1 IDLE cycle, then wall plays for 20 cycles with period 10.
  - o_done pulses twice.
- **Paddle playing, score pulse 10 cycles in, SOUND_PREEMPT_EN defined:**
  - Required: o_active_id goes 2→3 two edges later with o_audio = 1 and no o_done.
  - Score plays its full 40 cycles; paddle never resumes.
- **Same stimulus, SOUND_PREEMPT_EN undefined:**
  - Required: paddle completes its 30 cycles, then gap, then score.
- **Three i_req_wall pulses during a single wall tone:**
  - Required: exactly one replay after the gap (merge).
- **reset_n low for 1 cycle mid-tone with a wall request pending:**
  - Required: all outputs 0 on the next edge; nothing plays afterwards without a new request.

Source files
------------

// File: rtl/pong_sound_sequencer.sv
// Shares one audio pin among wall, paddle and score events: latched requests, fixed priority, tone then gap.
// Optional SOUND_PREEMPT_EN: a higher-priority pending request restarts PLAY immediately.
module pong_sound_sequencer #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned MS_CYCLES   = CLK_HZ / 1000,
    parameter int unsigned HALF_WALL   = 50_000,
    parameter int unsigned HALF_PADDLE = 25_000,
    parameter int unsigned HALF_SCORE  = 100_000,
    parameter int unsigned DUR_WALL    = 30,
    parameter int unsigned DUR_PADDLE  = 50,
    parameter int unsigned DUR_SCORE   = 300,
    parameter int unsigned GAP_MS      = 20
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       i_req_wall,
    input  logic       i_req_paddle,
    input  logic       i_req_score,
    output logic       o_audio,
    output logic       o_busy,
    output logic [1:0] o_active_id,
    output logic       o_done
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAXV = max2(max2(max2(MS_CYCLES, HALF_WALL), max2(HALF_PADDLE, HALF_SCORE)),
                                        max2(max2(DUR_WALL, DUR_PADDLE), max2(DUR_SCORE, GAP_MS)));
    localparam int unsigned CW = $clog2(MAXV) + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_GAP = 2'd2} state_t;

    localparam cnt_t MS_LAST = cnt_t'(MS_CYCLES - 1);
    localparam cnt_t GAP_LD  = cnt_t'((GAP_MS == 0) ? 1 : GAP_MS);

    function automatic cnt_t half_last(input logic [1:0] id);
        case (id)
            2'd1:    return cnt_t'(HALF_WALL - 1);
            2'd2:    return cnt_t'(HALF_PADDLE - 1);
            2'd3:    return cnt_t'(HALF_SCORE - 1);
            default: return '0;
        endcase
    endfunction

    function automatic cnt_t dur_load(input logic [1:0] id);
        case (id)
            2'd1:    return cnt_t'((DUR_WALL == 0) ? 1 : DUR_WALL);
            2'd2:    return cnt_t'((DUR_PADDLE == 0) ? 1 : DUR_PADDLE);
            2'd3:    return cnt_t'((DUR_SCORE == 0) ? 1 : DUR_SCORE);
            default: return cnt_t'(1);
        endcase
    endfunction

    state_t     state, state_n;
    logic [2:0] pend, pend_n, req, sel_mask;
    cnt_t       half_cnt, half_n, ms_cnt, ms_n, rem_cnt, rem_n;
    logic       audio_n, done_n;
    logic [1:0] active_n, top;
    logic       tick, preempt, do_start;

    // Bit order doubles as priority order: index+1 is the id.
    assign req  = {i_req_score, i_req_paddle, i_req_wall};
    assign top  = pend[2] ? 2'd3 : pend[1] ? 2'd2 : pend[0] ? 2'd1 : 2'd0;
    assign tick = (ms_cnt == MS_LAST);

`ifdef SOUND_PREEMPT_EN
    assign preempt = (state == S_PLAY) && (top > o_active_id);
`else
    assign preempt = 1'b0;
`endif

    assign do_start = ((state == S_IDLE) && (top != 2'd0)) || preempt;

    always_comb begin
        sel_mask = '0;
        case (top)
            2'd1:    sel_mask = 3'b001;
            2'd2:    sel_mask = 3'b010;
            2'd3:    sel_mask = 3'b100;
            default: sel_mask = '0;
        endcase
    end

    always_comb begin
        state_n  = state;
        pend_n   = pend | req;
        half_n   = half_cnt;
        ms_n     = ms_cnt;
        rem_n    = rem_cnt;
        audio_n  = o_audio;
        active_n = o_active_id;
        done_n   = 1'b0;

        if (do_start) begin
            // A request arriving on the selection edge keeps the bit set, so the tone replays.
            pend_n   = (pend & ~sel_mask) | req;
            state_n  = S_PLAY;
            half_n   = '0;
            ms_n     = '0;
            rem_n    = dur_load(top);
            audio_n  = 1'b1;
            active_n = top;
        end else begin
            case (state)
                S_PLAY: begin
                    ms_n = tick ? '0 : ms_cnt + cnt_t'(1);
                    if (half_cnt == half_last(o_active_id)) begin
                        half_n  = '0;
                        audio_n = ~o_audio;
                    end else begin
                        half_n = half_cnt + cnt_t'(1);
                    end
                    if (tick) begin
                        if (rem_cnt == cnt_t'(1)) begin
                            state_n  = S_GAP;
                            audio_n  = 1'b0;
                            done_n   = 1'b1;
                            active_n = 2'd0;
                            half_n   = '0;
                            rem_n    = GAP_LD;
                        end else begin
                            rem_n = rem_cnt - cnt_t'(1);
                        end
                    end
                end
                S_GAP: begin
                    ms_n = tick ? '0 : ms_cnt + cnt_t'(1);
                    if (tick) begin
                        if (rem_cnt == cnt_t'(1)) begin
                            state_n = S_IDLE;
                            rem_n   = '0;
                        end else begin
                            rem_n = rem_cnt - cnt_t'(1);
                        end
                    end
                end
                S_IDLE: ;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            pend        <= '0;
            half_cnt    <= '0;
            ms_cnt      <= '0;
            rem_cnt     <= '0;
            o_audio     <= 1'b0;
            o_busy      <= 1'b0;
            o_active_id <= 2'd0;
            o_done      <= 1'b0;
        end else begin
            state       <= state_n;
            pend        <= pend_n;
            half_cnt    <= half_n;
            ms_cnt      <= ms_n;
            rem_cnt     <= rem_n;
            o_audio     <= audio_n;
            o_busy      <= (state_n != S_IDLE);
            o_active_id <= active_n;
            o_done      <= done_n;
        end
    end

endmodule
